// File: rtl/adder_arbiter_2ch.sv
// ---------------------------------------------------------------------------
// adder_arbiter_2ch
//
// Shares one full_add_8bit between two requesters. A winner is picked in
// IDLE, its operands are captured into registers that feed the adder, and
// the registered sum/carry is returned with the owning channel's index over
// a valid/ready response handshake.
//
// Build option:
//   ADD_ARB_RR_EN  defined   -> round-robin between the channels
//                  undefined -> fixed priority, channel 0 wins
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/req1           channel requests (held until granted)
//   a0,b0,cin0          channel 0 operands
//   a1,b1,cin1          channel 1 operands
//   gnt0/gnt1           one-cycle grant pulse, coincident with capture
//   rsp_valid/rsp_ready response handshake
//   rsp_sum/rsp_cout    registered 8-bit sum and carry-out
//   rsp_id              channel that owns the current response
// ---------------------------------------------------------------------------

// Plain 8-bit ripple-style adder; the arbiter owns exactly one of these.
module full_add_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // Widen everything to 9 bits so the carry lands in the top bit.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

module adder_arbiter_2ch (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       cin0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       cin1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_sum,
    output logic       rsp_cout,
    output logic       rsp_id
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_cin;
    logic       last_id;

    logic [7:0] add_sum;
    logic       add_cout;
    logic       grant_any;
    logic       grant_id;

    // The shared adder only ever sees the captured operands, so its result
    // is stable for the whole CALC cycle regardless of what the requesters do.
    full_add_8bit u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Grant decode. Grants exist only in IDLE; in round-robin mode a tie
    // goes to the channel that did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
`ifdef ADD_ARB_RR_EN
            gnt0 = req0 & (~req1 | last_id);
            gnt1 = req1 & (~req0 | ~last_id);
`else
            gnt0 = req0;
            gnt1 = req1 & ~req0;
`endif
        end
        grant_any = gnt0 | gnt1;
        grant_id  = gnt1;
    end

    // Sequencer: IDLE captures the winner, CALC registers the adder result,
    // RESP holds it until the consumer takes it. Reset drops any result in
    // flight and makes channel 0 the first round-robin winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= 8'h00;
            op_b      <= 8'h00;
            op_cin    <= 1'b0;
            last_id   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_sum   <= 8'h00;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            // Grants only happen in IDLE, so this tracks the last winner.
            last_id <= grant_any ? grant_id : last_id;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a   <= grant_id ? a1 : a0;
                        op_b   <= grant_id ? b1 : b0;
                        op_cin <= grant_id ? cin1 : cin0;
                        rsp_id <= grant_id;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= add_sum;
                    rsp_cout  <= add_cout;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter_2ch.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter_2ch
//
// Directed scenarios followed by a long randomized run against a
// transaction-level model (one outstanding result, age in cycles since the
// grant, arbitration decided from the policy rules). Honours ADD_ARB_RR_EN
// the same way the design does.
// ---------------------------------------------------------------------------
module tb_adder_arbiter_2ch;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic       cin0, cin1;
    logic       gnt0, gnt1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_sum;
    logic       rsp_cout;
    logic       rsp_id;

    int total = 0;
    int bad   = 0;

    adder_arbiter_2ch dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .cin0      (cin0),
        .a1        (a1),
        .b1        (b1),
        .cin1      (cin1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Arbitration policy expressed as a rule: -1 means nobody wins.
    function automatic int pick(bit r0, bit r1, bit last);
        if (!r0 && !r1) return -1;
`ifdef ADD_ARB_RR_EN
        if (r0 && r1) return last ? 0 : 1;
`else
        if (r0) return 0;
`endif
        return r0 ? 0 : 1;
    endfunction

    // Drive every input to its quiet value.
    task automatic clear_inputs();
        req0 = 0; req1 = 0; rsp_ready = 0;
        a0 = 0; b0 = 0; cin0 = 0;
        a1 = 0; b1 = 0; cin1 = 0;
    endtask

    // Two reset cycles, released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Outputs while reset is applied.
    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_gnt: got %b expected 00", {gnt0, gnt1});
        end
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid);
        end
        total++;
        if ({rsp_cout, rsp_sum, rsp_id} !== 10'h000) begin
            bad++; $display("[TB] FAIL reset_rsp: got cout=%b sum=%h id=%b expected 0/00/0",
                            rsp_cout, rsp_sum, rsp_id);
        end
        @(negedge clk);
        rst = 0;
    endtask

    // Single channel-0 request, result two cycles after the grant.
    task automatic test_single();
        do_reset();
        req0 = 1; a0 = 8'h0F; b0 = 8'h01; cin0 = 0; rsp_ready = 1;
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++; $display("[TB] FAIL single_gnt: got %b expected 10", {gnt0, gnt1});
        end
        @(negedge clk);
        req0 = 0;
        #1;
        total++;
        if ({gnt0, rsp_valid} !== 2'b00) begin
            bad++; $display("[TB] FAIL single_calc: got gnt0=%b valid=%b expected 0 0", gnt0, rsp_valid);
        end
        @(negedge clk);
        #1;
        total++;
        if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin
            bad++; $display("[TB] FAIL single_rsp: got v=%b c=%b s=%h id=%b expected 1 0 10 0",
                            rsp_valid, rsp_cout, rsp_sum, rsp_id);
        end
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL single_drop: got %b expected 0", rsp_valid);
        end
    endtask

    // Channel 1 with carry out, response held under backpressure.
    task automatic test_backpressure();
        do_reset();
        req1 = 1; a1 = 8'hFF; b1 = 8'h01; cin1 = 1; rsp_ready = 0;
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin
            bad++; $display("[TB] FAIL bp_gnt: got %b expected 01", {gnt0, gnt1});
        end
        @(negedge clk);
        req1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {1'b1, 1'b1, 8'h01, 1'b1}) begin
                bad++; $display("[TB] FAIL bp_hold%0d: got v=%b c=%b s=%h id=%b expected 1 1 01 1",
                                i, rsp_valid, rsp_cout, rsp_sum, rsp_id);
            end
        end
        @(negedge clk);
        rsp_ready = 1;
        #1;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_accept: got %b expected 1", rsp_valid);
        end
        @(negedge clk);
        rsp_ready = 0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_drop: got %b expected 0", rsp_valid);
        end
    endtask

    // Both channels requesting continuously: grant every third cycle.
    task automatic test_back_to_back();
        int w;
        do_reset();
        req0 = 1; req1 = 1; rsp_ready = 1;
        a0 = 8'h12; b0 = 8'h34; a1 = 8'h56; b1 = 8'h78;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
`ifdef ADD_ARB_RR_EN
            w = (i % 3 == 0) ? (i / 3) % 2 : -1;
`else
            w = (i % 3 == 0) ? 0 : -1;
`endif
            total++;
            if (gnt0 !== (w == 0) || gnt1 !== (w == 1)) begin
                bad++; $display("[TB] FAIL b2b_cycle%0d: got gnt=%b%b expected %b%b",
                                i, gnt0, gnt1, (w == 0), (w == 1));
            end
        end
        clear_inputs();
    endtask

    // A request raised while busy waits for the first IDLE cycle.
    task automatic test_late_req();
        do_reset();
        req0 = 1; a0 = 8'h01; b0 = 8'h02;
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++; $display("[TB] FAIL late_first: got %b expected 10", {gnt0, gnt1});
        end
        @(negedge clk);
        req0 = 0; req1 = 1; a1 = 8'h40; b1 = 8'h41;
        #1;
        total++;
        if (gnt1 !== 1'b0) begin
            bad++; $display("[TB] FAIL late_calc: got gnt1=%b expected 0", gnt1);
        end
        @(negedge clk);
        #1;
        total++;
        if ({gnt1, rsp_valid} !== 2'b01) begin
            bad++; $display("[TB] FAIL late_resp: got gnt1=%b valid=%b expected 0 1", gnt1, rsp_valid);
        end
        @(negedge clk);
        rsp_ready = 1;
        #1;
        total++;
        if (gnt1 !== 1'b0) begin
            bad++; $display("[TB] FAIL late_accept: got gnt1=%b expected 0", gnt1);
        end
        @(negedge clk);
        rsp_ready = 0;
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin
            bad++; $display("[TB] FAIL late_gnt1: got %b expected 01", {gnt0, gnt1});
        end
        clear_inputs();
    endtask

    // Reset while a result is waiting: it vanishes and channel 0 wins next.
    task automatic test_reset_resp();
        do_reset();
        req0 = 1; a0 = 8'h33; b0 = 8'h44;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL rr_pending: got %b expected 1", rsp_valid);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        req0 = 1; req1 = 1;
        #1;
        total++;
        if ({rsp_valid, rsp_sum, rsp_id} !== 10'h000) begin
            bad++; $display("[TB] FAIL rr_cleared: got v=%b s=%h id=%b expected 0 00 0",
                            rsp_valid, rsp_sum, rsp_id);
        end
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++; $display("[TB] FAIL rr_first: got %b expected 10", {gnt0, gnt1});
        end
        @(negedge clk);
        req0 = 0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rr_calc: got %b expected 0", rsp_valid);
        end
        clear_inputs();
    endtask

    // Randomized traffic against a transaction-level model.
    task automatic test_random();
        bit         p0 = 0, p1 = 0, c0 = 0, c1 = 0;
        logic [7:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
        bit         busy = 0, mlast = 1, exp_id = 0, exp_valid;
        logic [8:0] exp_res = 0;
        int         age = 0, accepted = 0, cycles = 0, w;
        do_reset();
        while (accepted < 1000 && cycles < 40000) begin
            @(negedge clk);
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; x0 = 8'($urandom); y0 = 8'($urandom); c0 = 1'($urandom);
            end else if (p0 && $urandom_range(0, 15) == 0) begin
                p0 = 0;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; x1 = 8'($urandom); y1 = 8'($urandom); c1 = 1'($urandom);
            end else if (p1 && $urandom_range(0, 15) == 0) begin
                p1 = 0;
            end
            req0 = p0; a0 = x0; b0 = y0; cin0 = c0;
            req1 = p1; a1 = x1; b1 = y1; cin1 = c1;
            rsp_ready = 1'($urandom);
            #1;
            w = busy ? -1 : pick(p0, p1, mlast);
            total++;
            if (gnt0 !== (w == 0) || gnt1 !== (w == 1)) begin
                bad++; $display("[TB] FAIL rand_gnt cyc%0d: got %b%b expected %b%b",
                                cycles, gnt0, gnt1, (w == 0), (w == 1));
            end
            exp_valid = busy && age >= 2;
            total++;
            if (rsp_valid !== exp_valid) begin
                bad++; $display("[TB] FAIL rand_valid cyc%0d: got %b expected %b", cycles, rsp_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if ({rsp_cout, rsp_sum} !== exp_res || rsp_id !== exp_id) begin
                    bad++; $display("[TB] FAIL rand_rsp cyc%0d: got %h id=%b expected %h id=%b",
                                    cycles, {rsp_cout, rsp_sum}, rsp_id, exp_res, exp_id);
                end
            end
            if (w >= 0) begin
                busy = 1; age = 0; mlast = (w == 1); exp_id = (w == 1);
                if (w == 1) begin
                    exp_res = {1'b0, x1} + {1'b0, y1} + {8'b0, c1};
                    p1 = 0;
                end else begin
                    exp_res = {1'b0, x0} + {1'b0, y0} + {8'b0, c0};
                    p0 = 0;
                end
            end else if (exp_valid && rsp_ready) begin
                busy = 0;
                accepted++;
            end
            age++;
            cycles++;
        end
        total++;
        if (accepted < 1000) begin
            bad++; $display("[TB] FAIL rand_timeout: got %0d accepted expected 1000", accepted);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_late_req();
        test_reset_resp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
